// File: rtl/wca_hal_pkg.sv
// Shared HAL definitions for the I/Q packer: mode encoding, port word type,
// and the 12-to-8-bit sample reduction. Optional macro WCA_IQ_PACKER_ROUND_EN
// switches the reduction from truncation to round-half-up with saturation.
package wca_hal_pkg;

    localparam logic MODE_16B = 1'b0;
    localparam logic MODE_8B  = 1'b1;

    typedef logic [31:0] port_word_t;

    // Packing phase in 8-bit mode: waiting for the first or second sample.
    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_t;

    // Reduce a sign-extended sample of width sw to its top 8 bits.
    // sw must be at least 9 so that the rounding constant is meaningful.
    function automatic logic [7:0] reduce8(input logic signed [31:0] x,
                                           input int unsigned        sw);
        logic signed [31:0] r;
`ifdef WCA_IQ_PACKER_ROUND_EN
        r = (x + (32'sd1 <<< (sw - 9))) >>> (sw - 8);
        if (r > 127) begin
            return 8'h7F;
        end else if (r < -128) begin
            return 8'h80;
        end else begin
            return r[7:0];
        end
`else
        r = x >>> (sw - 8);
        return r[7:0];
`endif
    endfunction

endpackage

// File: rtl/wca_word_fifo.sv
// Synchronous DEPTH-entry word FIFO with first-word-fall-through read port.
// A push while full is accepted only when a pop happens in the same cycle.
// Read data reads as zero while empty.
module wca_word_fifo
    import wca_hal_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  port_word_t wr_data,
    input  logic       pop,
    output port_word_t rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    port_word_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    // Next-state pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are qualified by occupancy so need no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/wca_iq_packer.sv
// I/Q sample packer: turns strobed SAMPLE_W-bit I/Q pairs into 32-bit port
// words (one pair per word in 16-bit mode, two pairs per word in 8-bit mode),
// buffers them in a small FIFO and counts words dropped on overflow.
// Optional macro WCA_IQ_PACKER_ROUND_EN enables rounding in 8-bit mode.
module wca_iq_packer
    import wca_hal_pkg::*;
#(
    parameter int SAMPLE_W = 12,
    parameter int DEPTH    = 4,
    parameter int OVF_W    = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                mode,
    input  logic                strobe_in,
    input  logic [SAMPLE_W-1:0] i_in,
    input  logic [SAMPLE_W-1:0] q_in,
    output logic [31:0]         out_data,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                clr_ovf,
    output logic                ovf_flag,
    output logic [OVF_W-1:0]    ovf_count
);

    phase_t              phase_q, phase_d;
    logic                mode_prev_q, mode_prev_d;
    logic [15:0]         hold_q, hold_d;
    logic                ovf_flag_q, ovf_flag_d;
    logic [OVF_W-1:0]    ovf_count_q, ovf_count_d;

    logic signed [31:0]  i_ext;
    logic signed [31:0]  q_ext;
    logic [7:0]          i8;
    logic [7:0]          q8;
    logic                accept;
    phase_t              phase_eff;
    logic                push;
    port_word_t          push_word;
    logic                pop;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;
    port_word_t          fifo_rd_data;

    assign i_ext  = {{(32-SAMPLE_W){i_in[SAMPLE_W-1]}}, i_in};
    assign q_ext  = {{(32-SAMPLE_W){q_in[SAMPLE_W-1]}}, q_in};
    assign i8     = reduce8(i_ext, SAMPLE_W);
    assign q8     = reduce8(q_ext, SAMPLE_W);
    assign accept = strobe_in && enable;

    // Word assembly: a mode change or disable restarts the pair, dropping any held half.
    always_comb begin
        phase_eff   = (mode != mode_prev_q || !enable) ? PH_FIRST : phase_q;
        phase_d     = phase_eff;
        hold_d      = hold_q;
        mode_prev_d = mode;
        push        = 1'b0;
        push_word   = '0;
        if (accept) begin
            if (mode == MODE_16B) begin
                push      = 1'b1;
                push_word = {q_ext[15:0], i_ext[15:0]};
            end else if (phase_eff == PH_FIRST) begin
                hold_d  = {q8, i8};
                phase_d = PH_SECOND;
            end else begin
                push      = 1'b1;
                push_word = {q8, i8, hold_q};
                phase_d   = PH_FIRST;
            end
        end
    end

    assign pop  = out_ready && !fifo_empty;
    assign drop = push && fifo_full && !pop;

    // Overflow bookkeeping: clear beats a coincident drop; count saturates.
    always_comb begin
        ovf_flag_d  = ovf_flag_q;
        ovf_count_d = ovf_count_q;
        if (clr_ovf) begin
            ovf_flag_d  = 1'b0;
            ovf_count_d = '0;
        end else if (drop) begin
            ovf_flag_d = 1'b1;
            if (ovf_count_q != '1) begin
                ovf_count_d = ovf_count_q + OVF_W'(1);
            end
        end
    end

    // Control state: packing phase, previous mode and overflow status.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase_q     <= PH_FIRST;
            mode_prev_q <= MODE_16B;
            ovf_flag_q  <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            phase_q     <= phase_d;
            mode_prev_q <= mode_prev_d;
            ovf_flag_q  <= ovf_flag_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    // Held first half-word; only meaningful while phase is PH_SECOND.
    always_ff @(posedge clock) begin
        hold_q <= hold_d;
    end

    wca_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (push_word),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rd_data;
    assign ovf_flag  = ovf_flag_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_wca_iq_packer.sv
// Testbench for wca_iq_packer: cycle table of directed vectors followed by
// hand-written overflow / full-FIFO sequences.
module tb_wca_iq_packer;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        mode;
    logic        strobe_in;
    logic [11:0] i_in;
    logic [11:0] q_in;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        clr_ovf;
    logic        ovf_flag;
    logic [7:0]  ovf_count;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef WCA_IQ_PACKER_ROUND_EN
    localparam logic [31:0] EXP_RND = 32'h0002_007F;
`else
    localparam logic [31:0] EXP_RND = 32'h0001_007F;
`endif

    // ctl = {reset_n, enable, mode, strobe_in, out_ready, clr_ovf}
    typedef struct {
        logic [5:0]  ctl;
        logic [11:0] i;
        logic [11:0] q;
        logic        ev;
        logic [31:0] ed;
        logic        ef;
        logic [7:0]  ec;
    } vec_t;

    localparam int NV = 30;
    vec_t tv [NV];

    wca_iq_packer #(
        .SAMPLE_W (12),
        .DEPTH    (4),
        .OVF_W    (8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .mode      (mode),
        .strobe_in (strobe_in),
        .i_in      (i_in),
        .q_in      (q_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .ovf_flag  (ovf_flag),
        .ovf_count (ovf_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply inputs at the falling edge, then wait until just after the rising edge.
    task automatic drive(input logic [5:0] ctl, input logic [11:0] i, input logic [11:0] q);
        @(negedge clock);
        {reset_n, enable, mode, strobe_in, out_ready, clr_ovf} = ctl;
        i_in = i;
        q_in = q;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] w16(input logic [11:0] i, input logic [11:0] q);
        return {{4{q[11]}}, q, {4{i[11]}}, i};
    endfunction

    initial begin
        reset_n = 1'b0; enable = 1'b0; mode = 1'b0; strobe_in = 1'b0;
        i_in = '0; q_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;

        tv[0]  = '{6'b000000, 12'h000, 12'h000, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[1]  = '{6'b100010, 12'h000, 12'h000, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[2]  = '{6'b110100, 12'h801, 12'h7FF, 1'b1, 32'h07FF_F801, 1'b0, 8'd0};
        tv[3]  = '{6'b110000, 12'h000, 12'h000, 1'b1, 32'h07FF_F801, 1'b0, 8'd0};
        tv[4]  = '{6'b110010, 12'h000, 12'h000, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[5]  = '{6'b111010, 12'h000, 12'h000, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[6]  = '{6'b111110, 12'h120, 12'h340, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[7]  = '{6'b111100, 12'h560, 12'h780, 1'b1, 32'h7856_3412, 1'b0, 8'd0};
        tv[8]  = '{6'b111010, 12'h000, 12'h000, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[9]  = '{6'b111110, 12'h7F8, 12'h000, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[10] = '{6'b111100, 12'h018, 12'h000, 1'b1, EXP_RND,       1'b0, 8'd0};
        tv[11] = '{6'b111010, 12'h000, 12'h000, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[12] = '{6'b111110, 12'h111, 12'h222, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[13] = '{6'b110010, 12'h000, 12'h000, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[14] = '{6'b111010, 12'h000, 12'h000, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[15] = '{6'b111110, 12'h330, 12'h440, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[16] = '{6'b111100, 12'h550, 12'h660, 1'b1, 32'h6655_4433, 1'b0, 8'd0};
        tv[17] = '{6'b111010, 12'h000, 12'h000, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[18] = '{6'b111110, 12'h770, 12'h880, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[19] = '{6'b101010, 12'h000, 12'h000, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[20] = '{6'b101110, 12'h990, 12'hAA0, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[21] = '{6'b111110, 12'h120, 12'h340, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[22] = '{6'b111100, 12'h560, 12'h780, 1'b1, 32'h7856_3412, 1'b0, 8'd0};
        tv[23] = '{6'b111010, 12'h000, 12'h000, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[24] = '{6'b111110, 12'h120, 12'h340, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[25] = '{6'b011110, 12'hABC, 12'hDEF, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[26] = '{6'b111110, 12'h560, 12'h780, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[27] = '{6'b111100, 12'h120, 12'h340, 1'b1, 32'h3412_7856, 1'b0, 8'd0};
        tv[28] = '{6'b011000, 12'h000, 12'h000, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
        tv[29] = '{6'b111000, 12'h000, 12'h000, 1'b0, 32'h0000_0000, 1'b0, 8'd0};

        for (int k = 0; k < NV; k++) begin
            drive(tv[k].ctl, tv[k].i, tv[k].q);
            chk($sformatf("row%0d out_valid", k), 32'(out_valid), 32'(tv[k].ev));
            chk($sformatf("row%0d out_data", k),  out_data,       tv[k].ed);
            chk($sformatf("row%0d ovf_flag", k),  32'(ovf_flag),  32'(tv[k].ef));
            chk($sformatf("row%0d ovf_count", k), 32'(ovf_count), 32'(tv[k].ec));
        end

        // Overflow: six words into a four-deep FIFO with the sink stalled.
        drive(6'b110000, 12'h000, 12'h000);
        for (int k = 1; k <= 6; k++) begin
            drive(6'b110100, 12'(k), 12'(12'h100 + k));
        end
        chk("ovf6 ovf_count", 32'(ovf_count), 32'd2);
        chk("ovf6 ovf_flag",  32'(ovf_flag),  32'd1);
        chk("ovf6 out_valid", 32'(out_valid), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain%0d out_data", k), out_data, w16(12'(k), 12'(12'h100 + k)));
            drive(6'b110010, 12'h000, 12'h000);
        end
        chk("drained out_valid", 32'(out_valid), 32'd0);
        drive(6'b110001, 12'h000, 12'h000);
        chk("clr ovf_count", 32'(ovf_count), 32'd0);
        chk("clr ovf_flag",  32'(ovf_flag),  32'd0);

        // Full FIFO: simultaneous push and pop must not drop.
        for (int k = 1; k <= 4; k++) begin
            drive(6'b110100, 12'(12'h010 + k), 12'(12'h020 + k));
        end
        drive(6'b110110, 12'h015, 12'h025);
        chk("pushpop ovf_count", 32'(ovf_count), 32'd0);
        chk("pushpop ovf_flag",  32'(ovf_flag),  32'd0);
        chk("pushpop out_data",  out_data, w16(12'h012, 12'h022));
        drive(6'b110100, 12'h016, 12'h026);
        chk("stillfull ovf_count", 32'(ovf_count), 32'd1);
        chk("stillfull ovf_flag",  32'(ovf_flag),  32'd1);
        drive(6'b110101, 12'h017, 12'h027);
        chk("clrdrop ovf_count", 32'(ovf_count), 32'd0);
        chk("clrdrop ovf_flag",  32'(ovf_flag),  32'd0);
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("fullorder%0d out_data", k), out_data,
                w16(12'(12'h010 + k), 12'(12'h020 + k)));
            drive(6'b110010, 12'h000, 12'h000);
        end
        chk("fullorder empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wca_iq_packer.md
Name: wca_iq_packer

Overview:
- Consumes strobe-qualified 12-bit I/Q samples from the RF/DDC path via the HAL passthrough signal bundle.
- Packs them into 32-bit words for the downstream port FIFO, using a valid/ready handshake.
- Two packing modes: 16-bit mode (one sample per word) and 8-bit mode (two samples per word).
- Buffers words in a small internal FIFO; counts words dropped on overflow.

Parameters:
- SAMPLE_W, 12, width of each I and Q input component (two's complement).
- DEPTH, 4, internal word FIFO depth (power of 2, ≥2).
- OVF_W, 8, width of the overflow counter.

Ports:
- clock  in  1  block clock.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  packing enable; low clears packing phase.
- mode  in  1  0 = 16-bit (1 sample/word), 1 = 8-bit (2 samples/word).
- strobe_in  in  1  input sample valid, one cycle per sample.
- i_in  in  SAMPLE_W  in-phase sample.
- q_in  in  SAMPLE_W  quadrature sample.
- out_data  out  32  packed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts word.
- clr_ovf  in  1  clears ovf_count and ovf_flag.
- ovf_flag  out  1  sticky: at least one word dropped.
- ovf_count  out  OVF_W  saturating count of dropped words.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset_n is sampled on the rising edge of clock; reset is synchronous and active-low.
  - Reset values: out_valid=0, out_data=0, ovf_flag=0, ovf_count=0, FIFO empty, phase=0.
- Sample acceptance:
  - A sample is accepted only when strobe_in=1 and enable=1.
  - When enable=0, strobes are ignored and phase is cleared to 0.
  - Words already in the FIFO continue to drain while enable=0.
- 16-bit mode (mode=0):
  - Each accepted sample completes one word.
  - Word = {sext16(q_in), sext16(i_in)}.
- 8-bit mode (mode=1):
  - Each component is reduced to 8 bits by taking x[SAMPLE_W-1:SAMPLE_W-8] (truncation).
  - Phase 0: store I0/Q0 in a holding register; phase becomes 1; no word is produced.
  - Phase 1: word = {Q1, I1, Q0, I0}, with I0 in bits [7:0]; phase returns to 0.
- Mode change:
  - mode is sampled every cycle.
  - If mode differs from its value in the previous cycle, phase clears to 0 and any held half-word is discarded.
- Push timing:
  - A completed word is pushed into the FIFO in the same cycle.
  - With the FIFO empty, out_valid rises on the next cycle (latency 1 clock from the completing strobe).
- Output handshake:
  - A word transfers when out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - Words leave in first-in, first-out order.
- Full FIFO:
  - Push while full with no pop in the same cycle: the word is dropped, ovf_flag is set, and ovf_count increments, saturating at all-ones.
  - Push while full with a pop in the same cycle: the push succeeds and occupancy is unchanged.
- Empty FIFO: pop with out_valid=0 is a no-op.
- Overflow clearing:
  - clr_ovf clears ovf_count and ovf_flag to 0.
  - If clr_ovf coincides with a drop, clear wins for that cycle; the drop is not counted.
- Pointers: FIFO read/write pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- Reset mid-operation: FIFO contents, held half-word and counters are all discarded.

Optional Feature:
- Macro: WCA_IQ_PACKER_ROUND_EN.
- Defined: 8-bit mode rounds half-up, i.e. adds 1<<(SAMPLE_W-9) before taking the top 8 bits.
  - Results are saturated to [-128, 127].
  - Example: 12'h7F8 gives 8'h7F, not a wrap.
- Undefined: plain truncation as specified above.
- 16-bit mode is unaffected either way.

Decomposition:
- Shared package wca_hal_pkg holds:
  - the mode encoding constants (MODE_16B=0, MODE_8B=1);
  - the 32-bit port word type;
  - the 8-bit reduce function (truncate/round-saturate, selected by the macro).
- One sub-module: wca_word_fifo, a synchronous DEPTH-entry FIFO.
  - Interface: push/pop/full/empty plus first-word-fall-through output.
  - The packer front end instantiates it.

Test Plan:
1. Reset, then mode=0, one strobe with i=12'h801, q=12'h7FF -> next cycle out_valid=1, out_data=32'h07FF_F801.
2. mode=1, strobes (I,Q)=(12'h120,12'h340) then (12'h560,12'h780) -> one word 32'h7856_3412; no word after the first strobe.
3. out_ready=0, mode=0, 6 consecutive strobes with DEPTH=4 -> 4 words held, ovf_count=2, ovf_flag=1; then out_ready=1 -> 4 words in input order; clr_ovf -> count 0, flag 0.
4. FIFO full, strobe and pop in the same cycle -> no drop, ovf_count unchanged, occupancy stays 4.
5. mode=1: one strobe, toggle mode, toggle back, then two strobes -> word contains only the last two samples; enable=0 mid-pair likewise discards the half-word.
6. With WCA_IQ_PACKER_ROUND_EN, mode=1, i=12'h7F8 -> byte 8'h7F; i=12'h018 -> 8'h02. Without the macro -> 8'h7F and 8'h01.
